// File: rtl/uart_mmio_pkg.sv
// Shared constants for the memory-mapped UART responder: select nibble,
// register offsets, status bit positions and the default FIFO depth.
package uart_mmio_pkg;

  localparam int unsigned DEFAULT_DEPTH = 8;

  localparam logic [3:0] SEL_NIBBLE = 4'h8;

  localparam logic [7:0] OFF_STATUS   = 8'h00;
  localparam logic [7:0] OFF_RX_DATA  = 8'h04;
  localparam logic [7:0] OFF_TX_DATA  = 8'h08;
  localparam logic [7:0] OFF_FLAG_CLR = 8'h0C;
  localparam logic [7:0] OFF_CYCLE    = 8'h10;
  localparam logic [7:0] OFF_INST     = 8'h14;
  localparam logic [7:0] OFF_CNT_CLR  = 8'h18;

  localparam int unsigned ST_TX_NOT_FULL  = 0;
  localparam int unsigned ST_RX_NOT_EMPTY = 1;
  localparam int unsigned ST_RX_OVF       = 2;
  localparam int unsigned ST_TX_DROP      = 3;

  function automatic logic [31:0] pack_status(input logic tx_not_full,
                                              input logic rx_not_empty,
                                              input logic rx_ovf,
                                              input logic tx_drop);
    logic [31:0] s;
    s = '0;
    s[ST_TX_NOT_FULL]  = tx_not_full;
    s[ST_RX_NOT_EMPTY] = rx_not_empty;
    s[ST_RX_OVF]       = rx_ovf;
    s[ST_TX_DROP]      = tx_drop;
    return s;
  endfunction

endpackage

// File: rtl/uart_mmio_responder_sync_fifo.sv
// Synchronous power-of-two FIFO with a combinational head. A push into a full
// FIFO is accepted only when a pop happens in the same cycle; no bypass.
module sync_fifo
  import uart_mmio_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_en, pop_en;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_COUNT);
  assign pop_data = mem_q[rd_ptr_q];
  assign pop_en   = pop && !empty;
  assign push_en  = push && (!full || pop_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// Memory-mapped UART responder: RX/TX byte FIFOs, sticky loss flags and
// free-running cycle / retired-instruction counters behind a CPU load/store port.
module uart_mmio_responder
  import uart_mmio_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic        req_re,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  input  logic        inst_retire,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] inst_q, inst_d;
  logic        rx_ovf_q, rx_ovf_d;
  logic        tx_drop_q, tx_drop_d;

  logic        sel, is_store, is_load;
  logic [7:0]  offset;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  rx_head;
  logic        flag_clr, cnt_clr;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{req_addr[27:8], req_wdata[31:8]};

  assign sel      = (req_addr[31:28] == SEL_NIBBLE);
  assign offset   = req_addr[7:0];
  // A cycle carrying both a load and a store is handled as a store only.
  assign is_store = sel && (req_we != 4'b0000);
  assign is_load  = sel && req_re && (req_we == 4'b0000);

  assign rx_ready = !rst;
  assign rx_push  = rx_valid && !rst;
  assign rx_pop   = is_load && (offset == OFF_RX_DATA);

  assign tx_valid = !tx_empty && !rst;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = is_store && (offset == OFF_TX_DATA) && req_we[0];

  assign flag_clr = is_store && (offset == OFF_FLAG_CLR);
  assign cnt_clr  = is_store && (offset == OFF_CNT_CLR);

  assign status = pack_status(!tx_full, !rx_empty, rx_ovf_q, tx_drop_q);
  assign rdata  = rdata_q;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (req_wdata[7:0]),
    .pop       (tx_pop),
    .pop_data  (tx_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  always_comb begin
    rdata_d = rdata_q;
    if (req_re && (req_we == 4'b0000)) begin
      rdata_d = '0;
      if (sel) begin
        case (offset)
          OFF_STATUS:  rdata_d = status;
          OFF_RX_DATA: rdata_d = rx_empty ? '0 : {24'b0, rx_head};
          OFF_CYCLE:   rdata_d = cycle_q;
          OFF_INST:    rdata_d = inst_q;
          default:     rdata_d = '0;
        endcase
      end
    end
  end

  // Full FIFOs still accept when a pop lands in the same cycle, so loss is
  // flagged only when no pop frees a slot; a new loss overrides a clear.
  always_comb begin
    rx_ovf_d  = rx_ovf_q;
    tx_drop_d = tx_drop_q;
    if (flag_clr && req_wdata[2]) rx_ovf_d  = 1'b0;
    if (flag_clr && req_wdata[3]) tx_drop_d = 1'b0;
    if (rx_push && rx_full && !rx_pop) rx_ovf_d  = 1'b1;
    if (tx_push && tx_full && !tx_pop) tx_drop_d = 1'b1;
  end

  always_comb begin
    cycle_d = cnt_clr ? '0 : cycle_q + 32'd1;
    inst_d  = cnt_clr ? '0 : inst_q + {31'b0, inst_retire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      cycle_q   <= '0;
      inst_q    <= '0;
      rx_ovf_q  <= 1'b0;
      tx_drop_q <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      cycle_q   <= cycle_d;
      inst_q    <= inst_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_drop_q <= tx_drop_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Self-checking bench for uart_mmio_responder: directed scenarios plus a
// randomized run, all checked against a queue-based behavioural model.
module tb_uart_mmio_responder;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_addr;
  logic        req_re;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        inst_retire;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  uart_mmio_responder #(.DEPTH(DEPTH)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_addr    (req_addr),
    .req_re      (req_re),
    .req_we      (req_we),
    .req_wdata   (req_wdata),
    .rdata       (rdata),
    .inst_retire (inst_retire),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready)
  );

  int unsigned cmp_count = 0;
  int unsigned err_count = 0;

  // Behavioural model state
  logic [7:0]  rx_m[$];
  logic [7:0]  tx_m[$];
  logic [7:0]  tx_exp[$];
  logic [7:0]  tx_seen[$];
  logic        ovf_m, drop_m;
  logic [31:0] cyc_m, inst_m, exp_rdata;

  function automatic logic [31:0] model_status();
    return {28'b0, drop_m, ovf_m, rx_m.size() != 0, tx_m.size() < DEPTH};
  endfunction

  // Advance one clock: record what the DUT emits, update the model from the
  // current inputs, then step to just after the edge.
  task automatic cycle();
    logic       sel, is_store, is_load, rx_popped, tx_popped, ovf_set, drop_set;
    logic [7:0] off;
    int         rx_n, tx_n;
    #1;
    if (tx_valid === 1'b1 && tx_ready) tx_seen.push_back(tx_data);
    sel      = (req_addr[31:28] == 4'h8);
    off      = req_addr[7:0];
    is_store = sel && (req_we != 4'b0);
    is_load  = req_re && (req_we == 4'b0);
    if (rst) begin
      rx_m.delete();
      tx_m.delete();
      ovf_m = 0; drop_m = 0;
      cyc_m = 0; inst_m = 0;
      exp_rdata = 0;
    end else begin
      rx_n = rx_m.size(); tx_n = tx_m.size();
      rx_popped = 0; tx_popped = 0; ovf_set = 0; drop_set = 0;
      if (is_load) begin
        exp_rdata = 0;
        if (sel) begin
          case (off)
            8'h00: exp_rdata = model_status();
            8'h04: if (rx_n > 0) begin
                     exp_rdata = {24'b0, rx_m.pop_front()};
                     rx_popped = 1;
                   end
            8'h10: exp_rdata = cyc_m;
            8'h14: exp_rdata = inst_m;
            default: exp_rdata = 0;
          endcase
        end
      end
      if (tx_n > 0 && tx_ready) begin
        tx_exp.push_back(tx_m.pop_front());
        tx_popped = 1;
      end
      if (rx_valid) begin
        if (rx_n < DEPTH || rx_popped) rx_m.push_back(rx_data);
        else ovf_set = 1;
      end
      if (is_store && off == 8'h08 && req_we[0]) begin
        if (tx_n < DEPTH || tx_popped) tx_m.push_back(req_wdata[7:0]);
        else drop_set = 1;
      end
      if (is_store && off == 8'h0C) begin
        if (req_wdata[2]) ovf_m = 0;
        if (req_wdata[3]) drop_m = 0;
      end
      if (ovf_set) ovf_m = 1;
      if (drop_set) drop_m = 1;
      if (is_store && off == 8'h18) begin
        cyc_m = 0; inst_m = 0;
      end else begin
        cyc_m = cyc_m + 32'd1;
        inst_m = inst_m + {31'b0, inst_retire};
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [31:0] a);
    req_addr = a; req_re = 1'b1;
    cycle();
    req_re = 1'b0; req_addr = '0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    req_addr = a; req_wdata = d; req_we = 4'hF;
    cycle();
    req_we = 4'h0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    cycle();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    cmp_count++;
    if (rx_ready !== 1'b0 || tx_valid !== 1'b0) begin
      err_count++;
      $display("FAIL reset_handshake: rx_ready=%b tx_valid=%b required 0 0", rx_ready, tx_valid);
    end
    idle(2);
    rst = 1'b0;
    #1;
    cmp_count++;
    if (rdata !== 32'h0 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      err_count++;
      $display("FAIL reset_state: rdata=%h tx_valid=%b rx_ready=%b required 0 0 1", rdata, tx_valid, rx_ready);
    end
    do_load(32'h8000_0000);
    cmp_count++;
    if (rdata !== exp_rdata || rdata !== 32'h1) begin
      err_count++;
      $display("FAIL reset_status: got %h required 00000001", rdata);
    end
  endtask

  task automatic test_rx_basic();
    push_rx(8'h41);
    push_rx(8'h42);
    do_load(32'h8000_0004);
    cmp_count++;
    if (rdata !== exp_rdata || rdata !== 32'h41) begin
      err_count++; $display("FAIL rx_pop1: got %h required 00000041", rdata);
    end
    do_load(32'h8000_0004);
    cmp_count++;
    if (rdata !== exp_rdata || rdata !== 32'h42) begin
      err_count++; $display("FAIL rx_pop2: got %h required 00000042", rdata);
    end
    do_load(32'h8000_0004);
    cmp_count++;
    if (rdata !== 32'h0) begin
      err_count++; $display("FAIL rx_pop_empty: got %h required 00000000", rdata);
    end
    do_load(32'h8000_0000);
    cmp_count++;
    if (rdata !== exp_rdata || rdata !== 32'h1) begin
      err_count++; $display("FAIL rx_status: got %h required 00000001", rdata);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [3];
    addrs[0] = 32'h7000_0000; addrs[1] = 32'h8000_0008; addrs[2] = 32'h8000_001C;
    for (int i = 0; i < 3; i++) begin
      do_load(32'h8000_0000);
      do_load(addrs[i]);
      cmp_count++;
      if (rdata !== 32'h0 || exp_rdata !== 32'h0) begin
        err_count++; $display("FAIL unmapped_load[%0d]: got %h required 00000000", i, rdata);
      end
    end
    do_load(32'h8000_0000);
    idle(3);
    req_addr = 32'h8000_0000; req_re = 1'b1; req_we = 4'h1; req_wdata = 32'hFF;
    cycle();
    req_addr = '0; req_re = 1'b0; req_we = 4'h0; req_wdata = '0;
    cmp_count++;
    if (rdata !== 32'h1) begin
      err_count++; $display("FAIL rdata_hold: got %h required 00000001", rdata);
    end
  endtask

  task automatic test_tx_overflow();
    tx_seen.delete(); tx_exp.delete();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) do_store(32'h8000_0008, 32'hA0 + i);
    do_load(32'h8000_0000);
    cmp_count++;
    if (rdata !== exp_rdata || rdata !== 32'h8) begin
      err_count++; $display("FAIL tx_drop_status: got %h required 00000008", rdata);
    end
    tx_ready = 1'b1;
    idle(12);
    cmp_count++;
    if (tx_seen.size() != 8 || tx_exp.size() != 8) begin
      err_count++; $display("FAIL tx_count: got %0d required 8", tx_seen.size());
    end
    for (int i = 0; i < tx_seen.size() && i < 8; i++) begin
      cmp_count++;
      if (tx_seen[i] !== 8'(32'hA0 + i)) begin
        err_count++; $display("FAIL tx_byte[%0d]: got %h required %h", i, tx_seen[i], 8'(32'hA0 + i));
      end
    end
    do_store(32'h8000_000C, 32'h8);
    do_load(32'h8000_0000);
    cmp_count++;
    if (rdata !== exp_rdata || rdata !== 32'h1) begin
      err_count++; $display("FAIL tx_drop_clear: got %h required 00000001", rdata);
    end
  endtask

  task automatic test_rx_overflow();
    for (int i = 0; i < 9; i++) push_rx(8'h30 + 8'(i));
    do_load(32'h8000_0000);
    cmp_count++;
    if (rdata !== exp_rdata || rdata !== 32'h7) begin
      err_count++; $display("FAIL rx_ovf_status: got %h required 00000007", rdata);
    end
    do_store(32'h8000_000C, 32'h4);
    do_load(32'h8000_0000);
    cmp_count++;
    if (rdata !== exp_rdata || rdata !== 32'h3) begin
      err_count++; $display("FAIL rx_ovf_clear: got %h required 00000003", rdata);
    end
    for (int i = 0; i < 8; i++) begin
      do_load(32'h8000_0004);
      cmp_count++;
      if (rdata !== {24'b0, 8'h30 + 8'(i)}) begin
        err_count++; $display("FAIL rx_drain[%0d]: got %h required %h", i, rdata, 8'h30 + 8'(i));
      end
    end
  endtask

  task automatic test_counters();
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i % 5) < 2;
      cycle();
    end
    inst_retire = 1'b0;
    do_load(32'h8000_0014);
    cmp_count++;
    if (rdata !== exp_rdata || rdata !== 32'd40) begin
      err_count++; $display("FAIL inst_count: got %0d required 40", rdata);
    end
    do_store(32'h8000_0018, 32'h0);
    idle(2);
    do_load(32'h8000_0010);
    cmp_count++;
    if (rdata !== exp_rdata || rdata !== 32'd2) begin
      err_count++; $display("FAIL cycle_after_clear: got %0d required 2", rdata);
    end
    do_load(32'h8000_0014);
    cmp_count++;
    if (rdata !== 32'd0) begin
      err_count++; $display("FAIL inst_after_clear: got %0d required 0", rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) push_rx(8'h50 + 8'(i));
    rx_valid = 1'b1; rx_data = 8'h77;
    do_load(32'h8000_0004);
    rx_valid = 1'b0;
    cmp_count++;
    if (rdata !== 32'h50) begin
      err_count++; $display("FAIL rx_full_pushpop: got %h required 00000050", rdata);
    end
    do_load(32'h8000_0000);
    cmp_count++;
    if (rdata !== exp_rdata || rdata !== 32'h3) begin
      err_count++; $display("FAIL rx_full_pushpop_status: got %h required 00000003", rdata);
    end
    for (int i = 0; i < DEPTH; i++) do_load(32'h8000_0004);
    cmp_count++;
    if (rdata !== 32'h77) begin
      err_count++; $display("FAIL rx_last_byte: got %h required 00000077", rdata);
    end
    rx_valid = 1'b1; rx_data = 8'h99;
    do_load(32'h8000_0004);
    rx_valid = 1'b0;
    cmp_count++;
    if (rdata !== 32'h0) begin
      err_count++; $display("FAIL rx_empty_pushpop: got %h required 00000000", rdata);
    end
    do_load(32'h8000_0004);
    cmp_count++;
    if (rdata !== 32'h99) begin
      err_count++; $display("FAIL rx_empty_pushpop_stored: got %h required 00000099", rdata);
    end
    tx_seen.delete(); tx_exp.delete();
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_store(32'h8000_0008, 32'hC0 + i);
    tx_ready = 1'b1;
    do_store(32'h8000_0008, 32'hEE);
    idle(12);
    do_load(32'h8000_0000);
    cmp_count++;
    if (rdata !== 32'h1) begin
      err_count++; $display("FAIL tx_full_pushpop_status: got %h required 00000001", rdata);
    end
    cmp_count++;
    if (tx_seen.size() != 9 || tx_seen[8] !== 8'hEE) begin
      err_count++; $display("FAIL tx_full_pushpop_stream: got %0d bytes required 9 ending EE", tx_seen.size());
    end
  endtask

  task automatic test_reset_midop();
    tx_seen.delete(); tx_exp.delete();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_store(32'h8000_0008, 32'h10 + i);
    rst = 1'b1;
    #1;
    cmp_count++;
    if (tx_valid !== 1'b0) begin
      err_count++; $display("FAIL midrst_tx_valid_in_reset: got %b required 0", tx_valid);
    end
    cycle();
    rst = 1'b0;
    #1;
    cmp_count++;
    if (tx_valid !== 1'b0) begin
      err_count++; $display("FAIL midrst_tx_valid_after: got %b required 0", tx_valid);
    end
    tx_ready = 1'b1;
    idle(10);
    cmp_count++;
    if (tx_seen.size() != 0 || tx_exp.size() != 0) begin
      err_count++; $display("FAIL midrst_emitted: got %0d bytes required 0", tx_seen.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] offs [6];
    int         k;
    offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h10;
    offs[3] = 8'h14; offs[4] = 8'h1C; offs[5] = 8'h08;
    tx_seen.delete(); tx_exp.delete();
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 149) == 0);
      rx_valid    = ($urandom_range(0, 2) == 0);
      rx_data     = 8'($urandom);
      tx_ready    = ($urandom_range(0, 3) != 0);
      inst_retire = 1'($urandom);
      req_re = 1'b0; req_we = 4'h0; req_addr = '0; req_wdata = $urandom;
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: begin req_re = 1'b1; req_addr = {4'h8, 20'($urandom), offs[$urandom_range(0, 5)]}; end
        3, 4:    begin req_we = 4'($urandom); req_addr = 32'h8000_0008; end
        5:       begin req_we = 4'hF; req_addr = 32'h8000_000C; end
        6:       begin req_re = 1'b1; req_addr = {4'h3, 28'($urandom)}; end
        7:       begin req_re = 1'b1; req_we = 4'h1; req_addr = 32'h8000_0004; end
        8:       if ($urandom_range(0, 7) == 0) begin req_we = 4'h2; req_addr = 32'h8000_0018; end
        default: ;
      endcase
      cycle();
      cmp_count++;
      if (rdata !== exp_rdata) begin
        err_count++; $display("FAIL random_rdata[%0d]: got %h required %h", n, rdata, exp_rdata);
      end
    end
    rst = 1'b0; rx_valid = 1'b0; inst_retire = 1'b0;
    req_re = 1'b0; req_we = 4'h0; req_addr = '0; req_wdata = '0;
    tx_ready = 1'b1;
    idle(DEPTH + 4);
    cmp_count++;
    if (tx_seen.size() != tx_exp.size()) begin
      err_count++; $display("FAIL random_tx_count: got %0d required %0d", tx_seen.size(), tx_exp.size());
    end
    for (int i = 0; i < tx_seen.size() && i < tx_exp.size(); i++) begin
      cmp_count++;
      if (tx_seen[i] !== tx_exp[i]) begin
        err_count++; $display("FAIL random_tx_byte[%0d]: got %h required %h", i, tx_seen[i], tx_exp[i]);
      end
    end
    do_load(32'h8000_0000);
    cmp_count++;
    if (rdata !== exp_rdata) begin
      err_count++; $display("FAIL random_status: got %h required %h", rdata, exp_rdata);
    end
  endtask

  initial begin
    rst = 1'b1; req_addr = '0; req_re = 1'b0; req_we = 4'h0; req_wdata = '0;
    inst_retire = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    ovf_m = 0; drop_m = 0; cyc_m = 0; inst_m = 0; exp_rdata = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_rx_basic();
    test_unmapped();
    test_tx_overflow();
    test_rx_overflow();
    test_counters();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
